// File: rtl/wakeup_tag_broadcaster.sv
// Transmit side of the scheduler wakeup bus: per-lane delay lines that broadcast each
// destination tag in the cycle its result becomes bypassable, plus a slot-free mask for select.
module wakeup_tag_broadcaster #(
    parameter int WAKEUP_WIDTH      = 4,
    parameter int INT_ISSUE_WIDTH   = 2,
    parameter int MAX_LATENCY       = 4,
    parameter int REG_NUM_BIT_WIDTH = 7,
    parameter int LAT_BIT_WIDTH     = $clog2(MAX_LATENCY + 1)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            stall,
    input  logic                                            flush,
    input  logic [WAKEUP_WIDTH-1:0]                         issue,
    input  logic [WAKEUP_WIDTH-1:0]                         issueDstValid,
    input  logic [WAKEUP_WIDTH-1:0][REG_NUM_BIT_WIDTH-1:0]  issueDstRegNum,
    input  logic [WAKEUP_WIDTH-1:0][LAT_BIT_WIDTH-1:0]      issueLatency,
    output logic [WAKEUP_WIDTH-1:0][MAX_LATENCY-1:0]        slotFree,
    output logic [WAKEUP_WIDTH-1:0]                         wakeup,
    output logic [WAKEUP_WIDTH-1:0]                         wakeupDstValid,
    output logic [WAKEUP_WIDTH-1:0][REG_NUM_BIT_WIDTH-1:0]  wakeupDstRegNum,
    output logic                                            busy,
    output logic                                            collision
);

    localparam int DEPTH = MAX_LATENCY - 1;
    localparam logic [LAT_BIT_WIDTH-1:0] LAT_ONE = LAT_BIT_WIDTH'(1);
    localparam logic [LAT_BIT_WIDTH-1:0] LAT_MAX = LAT_BIT_WIDTH'(MAX_LATENCY);

    typedef struct packed {
        logic                         valid;
        logic                         dstValid;
        logic [REG_NUM_BIT_WIDTH-1:0] regNum;
    } pendEntry_t;

    logic [WAKEUP_WIDTH-1:0] laneBusy;
    logic [WAKEUP_WIDTH-1:0] laneCollide;

    for (genvar k = 0; k < WAKEUP_WIDTH; k++) begin : gLane
        localparam bit IS_INT_LANE = (k < INT_ISSUE_WIDTH);

        pendEntry_t                   pend     [DEPTH];
        pendEntry_t                   pendNext [DEPTH];
        pendEntry_t                   newEntry;
        logic                         active;
        logic                         accept;
        logic                         targetBusy;
        logic [LAT_BIT_WIDTH-1:0]     lat;
        logic [MAX_LATENCY-1:0]       occ;
        logic                         laneWake;
        logic                         laneDstValid;
        logic [REG_NUM_BIT_WIDTH-1:0] laneRegNum;

        assign active = !(stall && IS_INT_LANE);

        // Latency 0 behaves as a bypass op; oversize latencies use the deepest slot.
        always_comb begin
            if (issueLatency[k] == '0) begin
                lat = LAT_ONE;
            end else if (issueLatency[k] > LAT_MAX) begin
                lat = LAT_MAX;
            end else begin
                lat = issueLatency[k];
            end
        end

        // occ[j] is the slot an op of latency j+1 would land in; the top bit has no entry.
        always_comb begin
            occ = '0;
            for (int d = 0; d < DEPTH; d++) begin
                occ[d] = pend[d].valid;
            end
        end

        always_comb begin
            newEntry.valid    = 1'b1;
            newEntry.dstValid = issueDstValid[k];
            newEntry.regNum   = issueDstRegNum[k];

            targetBusy = 1'b0;
            for (int j = 0; j < MAX_LATENCY; j++) begin
                if (lat == LAT_BIT_WIDTH'(j + 1)) begin
                    targetBusy = occ[j];
                end
            end

            accept = issue[k] && active && !flush;

            laneWake     = 1'b0;
            laneDstValid = 1'b0;
            laneRegNum   = '0;
            if (active && !flush && !rst) begin
                if (pend[0].valid) begin
                    laneWake     = 1'b1;
                    laneDstValid = pend[0].dstValid;
                    laneRegNum   = pend[0].regNum;
                end else if (accept && lat == LAT_ONE) begin
                    laneWake     = 1'b1;
                    laneDstValid = newEntry.dstValid;
                    laneRegNum   = newEntry.regNum;
                end
            end

            for (int d = 0; d < DEPTH; d++) begin
                pendNext[d] = pend[d];
            end
            if (active) begin
                for (int d = 0; d < DEPTH - 1; d++) begin
                    pendNext[d] = pend[d + 1];
                end
                pendNext[DEPTH-1] = '0;
                // A pending op always wins its slot; the colliding new op is dropped.
                if (accept && !targetBusy) begin
                    for (int d = 0; d < DEPTH; d++) begin
                        if (lat == LAT_BIT_WIDTH'(d + 2)) begin
                            pendNext[d] = newEntry;
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            for (int d = 0; d < DEPTH; d++) begin
                if (rst || flush) begin
                    pend[d] <= '0;
                end else begin
                    pend[d] <= pendNext[d];
                end
            end
        end

        assign laneCollide[k]     = accept && targetBusy;
        assign laneBusy[k]        = |occ;
        assign slotFree[k]        = active ? ~occ : '0;
        assign wakeup[k]          = laneWake;
        assign wakeupDstValid[k]  = laneDstValid;
        assign wakeupDstRegNum[k] = laneRegNum;
    end

    assign busy = |laneBusy;

    always_ff @(posedge clk) begin
        if (rst) begin
            collision <= 1'b0;
        end else if (|laneCollide) begin
            collision <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wakeup_tag_broadcaster.sv
// Directed self-checking bench for wakeup_tag_broadcaster: inputs change 1ns after the
// rising edge, outputs are sampled on the falling edge of the same cycle.
module tb_wakeup_tag_broadcaster;

    localparam int W   = 4;
    localparam int ML  = 4;
    localparam int RW  = 7;
    localparam int LW  = 3;

    logic                  clk;
    logic                  rst;
    logic                  stall;
    logic                  flush;
    logic [W-1:0]          issue;
    logic [W-1:0]          issueDstValid;
    logic [W-1:0][RW-1:0]  issueDstRegNum;
    logic [W-1:0][LW-1:0]  issueLatency;
    logic [W-1:0][ML-1:0]  slotFree;
    logic [W-1:0]          wakeup;
    logic [W-1:0]          wakeupDstValid;
    logic [W-1:0][RW-1:0]  wakeupDstRegNum;
    logic                  busy;
    logic                  collision;

    int compared   = 0;
    int mismatched = 0;

    wakeup_tag_broadcaster #(
        .WAKEUP_WIDTH(W), .INT_ISSUE_WIDTH(2), .MAX_LATENCY(ML),
        .REG_NUM_BIT_WIDTH(RW), .LAT_BIT_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .issue(issue), .issueDstValid(issueDstValid),
        .issueDstRegNum(issueDstRegNum), .issueLatency(issueLatency),
        .slotFree(slotFree), .wakeup(wakeup), .wakeupDstValid(wakeupDstValid),
        .wakeupDstRegNum(wakeupDstRegNum), .busy(busy), .collision(collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
        issue          = '0;
        issueDstValid  = '0;
        issueDstRegNum = '0;
        issueLatency   = '0;
        flush          = 1'b0;
    endtask

    task automatic applyStimulus(input int lane, input int regNum, input int lat, input logic dv);
        issue[lane]          = 1'b1;
        issueDstValid[lane]  = dv;
        issueDstRegNum[lane] = RW'(regNum);
        issueLatency[lane]   = LW'(lat);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        issue = '0; issueDstValid = '0; issueDstRegNum = '0; issueLatency = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset wakeup", 32'(wakeup), 0);
        checkOutput("reset dstValid", 32'(wakeupDstValid), 0);
        checkOutput("reset regNum", 32'(wakeupDstRegNum), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset slotFree", 32'(slotFree), 32'hFFFF);
        checkOutput("reset collision", 32'(collision), 0);

        // Lane 2, reg 35, latency 3
        nextCycle(); applyStimulus(2, 35, 3, 1'b1);
        @(negedge clk); checkOutput("L3 c0 wakeup", 32'(wakeup), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("L3 c1 wakeup", 32'(wakeup), 0);
        checkOutput("L3 c1 busy", 32'(busy), 1);
        checkOutput("L3 c1 slotFree2", 32'(slotFree[2]), 4'b1101);
        nextCycle();
        @(negedge clk);
        checkOutput("L3 c2 wakeup", 32'(wakeup), 4'b0100);
        checkOutput("L3 c2 reg", 32'(wakeupDstRegNum[2]), 35);
        checkOutput("L3 c2 busy", 32'(busy), 1);
        nextCycle();
        @(negedge clk);
        checkOutput("L3 c3 wakeup", 32'(wakeup), 0);
        checkOutput("L3 c3 busy", 32'(busy), 0);

        // Lane 0 bypass then latency 2
        nextCycle(); applyStimulus(0, 5, 1, 1'b1);
        @(negedge clk);
        checkOutput("bypass wakeup", 32'(wakeup), 4'b0001);
        checkOutput("bypass reg", 32'(wakeupDstRegNum[0]), 5);
        checkOutput("bypass dstValid", 32'(wakeupDstValid), 4'b0001);
        checkOutput("bypass busy", 32'(busy), 0);
        nextCycle(); applyStimulus(0, 9, 2, 1'b1);
        @(negedge clk); checkOutput("L2 issue wakeup", 32'(wakeup), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("L2 fire wakeup", 32'(wakeup), 4'b0001);
        checkOutput("L2 fire reg", 32'(wakeupDstRegNum[0]), 9);
        nextCycle();
        @(negedge clk); checkOutput("L2 after wakeup", 32'(wakeup), 0);

        // Stall freezes lanes 0/1 while lane 3 keeps firing
        nextCycle(); applyStimulus(1, 7, 2, 1'b1); applyStimulus(3, 40, 2, 1'b1);
        @(negedge clk); checkOutput("stall c0 wakeup", 32'(wakeup), 0);
        nextCycle(); stall = 1'b1; applyStimulus(3, 41, 2, 1'b1);
        @(negedge clk);
        checkOutput("stall c1 wakeup", 32'(wakeup), 4'b1000);
        checkOutput("stall c1 reg3", 32'(wakeupDstRegNum[3]), 40);
        checkOutput("stall c1 slotFree1", 32'(slotFree[1]), 0);
        checkOutput("stall c1 slotFree0", 32'(slotFree[0]), 0);
        nextCycle(); applyStimulus(3, 42, 2, 1'b1); applyStimulus(0, 3, 1, 1'b1);
        @(negedge clk);
        checkOutput("stall c2 wakeup", 32'(wakeup), 4'b1000);
        checkOutput("stall c2 reg3", 32'(wakeupDstRegNum[3]), 41);
        nextCycle();
        @(negedge clk);
        checkOutput("stall c3 wakeup", 32'(wakeup), 4'b1000);
        checkOutput("stall c3 reg3", 32'(wakeupDstRegNum[3]), 42);
        checkOutput("stall c3 busy", 32'(busy), 1);
        nextCycle(); stall = 1'b0;
        @(negedge clk);
        checkOutput("unstall wakeup", 32'(wakeup), 4'b0010);
        checkOutput("unstall reg1", 32'(wakeupDstRegNum[1]), 7);
        nextCycle();
        @(negedge clk);
        checkOutput("unstall after wakeup", 32'(wakeup), 0);
        checkOutput("unstall after busy", 32'(busy), 0);
        checkOutput("unstall collision", 32'(collision), 0);

        // Latency 0 acts as 1, latency 7 clamps to 4
        nextCycle(); applyStimulus(2, 30, 0, 1'b1); applyStimulus(3, 31, 7, 1'b1);
        @(negedge clk);
        checkOutput("lat0 wakeup", 32'(wakeup), 4'b0100);
        checkOutput("lat0 reg", 32'(wakeupDstRegNum[2]), 30);
        nextCycle();
        @(negedge clk);
        checkOutput("clamp c1 slotFree3", 32'(slotFree[3]), 4'b1011);
        checkOutput("clamp c1 wakeup", 32'(wakeup), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("clamp c2 slotFree3", 32'(slotFree[3]), 4'b1101);
        checkOutput("clamp c2 wakeup", 32'(wakeup), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("clamp c3 wakeup", 32'(wakeup), 4'b1000);
        checkOutput("clamp c3 reg", 32'(wakeupDstRegNum[3]), 31);

        // Collision: L=3 then L=2 into the occupied slot
        nextCycle(); applyStimulus(0, 20, 3, 1'b1);
        @(negedge clk); checkOutput("coll c0 wakeup", 32'(wakeup), 0);
        nextCycle(); applyStimulus(0, 21, 2, 1'b1);
        @(negedge clk);
        checkOutput("coll c1 slotFree0", 32'(slotFree[0]), 4'b1101);
        checkOutput("coll c1 collision", 32'(collision), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("coll c2 wakeup", 32'(wakeup), 4'b0001);
        checkOutput("coll c2 reg", 32'(wakeupDstRegNum[0]), 20);
        checkOutput("coll c2 collision", 32'(collision), 1);
        nextCycle();
        @(negedge clk);
        checkOutput("coll c3 wakeup", 32'(wakeup), 0);
        checkOutput("coll c3 busy", 32'(busy), 0);
        nextCycle();
        @(negedge clk); checkOutput("coll sticky", 32'(collision), 1);

        // Flush with all lanes pending and a same-cycle bypass on lane 3
        nextCycle();
        for (int k = 0; k < W; k++) applyStimulus(k, 50 + k, 3, 1'b1);
        @(negedge clk); checkOutput("flush c0 wakeup", 32'(wakeup), 0);
        nextCycle(); flush = 1'b1; applyStimulus(3, 60, 1, 1'b1);
        @(negedge clk);
        checkOutput("flush c1 wakeup", 32'(wakeup), 0);
        checkOutput("flush c1 regNum", 32'(wakeupDstRegNum), 0);
        checkOutput("flush c1 busy", 32'(busy), 1);
        nextCycle();
        @(negedge clk);
        checkOutput("flush c2 wakeup", 32'(wakeup), 0);
        checkOutput("flush c2 busy", 32'(busy), 0);
        checkOutput("flush collision kept", 32'(collision), 1);
        nextCycle();
        @(negedge clk); checkOutput("flush c3 wakeup", 32'(wakeup), 0);

        // dstValid=0 still broadcasts; then reset drops an L=4 op in flight
        nextCycle(); applyStimulus(1, 11, 2, 1'b0);
        @(negedge clk); checkOutput("nodst c0 wakeup", 32'(wakeup), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("nodst wakeup", 32'(wakeup), 4'b0010);
        checkOutput("nodst dstValid", 32'(wakeupDstValid), 0);
        checkOutput("nodst reg", 32'(wakeupDstRegNum[1]), 11);
        nextCycle(); applyStimulus(1, 12, 4, 1'b1);
        @(negedge clk); checkOutput("rstflight c0 wakeup", 32'(wakeup), 0);
        nextCycle(); rst = 1'b1;
        @(negedge clk);
        nextCycle(); rst = 1'b0;
        @(negedge clk);
        checkOutput("rstflight wakeup", 32'(wakeup), 0);
        checkOutput("rstflight dstValid", 32'(wakeupDstValid), 0);
        checkOutput("rstflight regNum", 32'(wakeupDstRegNum), 0);
        checkOutput("rstflight busy", 32'(busy), 0);
        checkOutput("rstflight slotFree", 32'(slotFree), 32'hFFFF);
        checkOutput("rstflight collision", 32'(collision), 0);
        nextCycle();
        @(negedge clk); checkOutput("rstflight after wakeup", 32'(wakeup), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
